// File: rtl/rf_write_arbiter_if.sv
// Writeback bus for rf_write_arbiter: two requester handshakes, the register-file
// write port, the pending-write query port and the conflict counter.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [0:DATA_W-1] alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [0:DATA_W-1] ld_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [0:DATA_W-1] rf_data;
    logic [ADDR_W-1:0] query_addr;
    logic              query_pending;
    logic              fwd_valid;
    logic [0:DATA_W-1] fwd_data;
    logic [CNT_W-1:0]  conflict_cnt;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  query_addr,
        output alu_ready, ld_ready,
        output rf_we, rf_addr, rf_data,
        output query_pending, fwd_valid, fwd_data, conflict_cnt
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output query_addr,
        input  alu_ready, ld_ready,
        input  rf_we, rf_addr, rf_data,
        input  query_pending, fwd_valid, fwd_data, conflict_cnt
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter draining two writeback FIFOs (ALU, load) into one register-file write port.
// Define RF_WRITE_FORWARD_EN to build the youngest-pending-write forwarding mux.
module rf_write_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    rf_write_arbiter_if.slave bus
);
    // state     | meaning
    // GRANT_ALU | last grant went to ALU; LD wins the next tie
    // GRANT_LD  | last grant went to LD (reset value); ALU wins the next tie
    typedef enum logic {GRANT_ALU = 1'b0, GRANT_LD = 1'b1} grant_e;

    localparam int            PTR_W  = $clog2(DEPTH);
    localparam int            REQ_LD = 1;
    localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(DEPTH);

    grant_e            last_grant, last_grant_nxt;
    logic [ADDR_W-1:0] mem_addr [2][DEPTH];
    logic [0:DATA_W-1] mem_data [2][DEPTH];
    logic [PTR_W-1:0]  rd_ptr [2];
    logic [PTR_W-1:0]  wr_ptr [2];
    logic [PTR_W:0]    count  [2];
    logic [DEPTH-1:0]  slot_valid [2];
    logic [ADDR_W-1:0] in_addr [2];
    logic [0:DATA_W-1] in_data [2];
    logic [1:0]        in_valid, ready, enq, head_valid, grant;
    logic [PTR_W-1:0]  age;
    logic              gsel;
    logic              q_hit;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_addr_q;
    logic [0:DATA_W-1] rf_data_q;
    logic [CNT_W-1:0]  conflict_q;

    assign in_valid   = {bus.ld_valid, bus.alu_valid};
    assign in_addr[0] = bus.alu_addr;
    assign in_addr[1] = bus.ld_addr;
    assign in_data[0] = bus.alu_data;
    assign in_data[1] = bus.ld_data;

    // Writes to register 0 complete the handshake but are dropped before the FIFO.
    always_comb begin
        ready      = '0;
        enq        = '0;
        head_valid = '0;
        age        = '0;
        for (int r = 0; r < 2; r++) begin
            slot_valid[r] = '0;
            ready[r]      = count[r] < FULL;
            enq[r]        = in_valid[r] && ready[r] && (in_addr[r] != '0);
            head_valid[r] = count[r] != '0;
            for (int s = 0; s < DEPTH; s++) begin
                age              = PTR_W'(s) - rd_ptr[r];
                slot_valid[r][s] = {1'b0, age} < count[r];
            end
        end
    end

    always_comb begin
        grant          = '0;
        last_grant_nxt = last_grant;
        grant[0] = head_valid[0] && (!head_valid[1] || last_grant == GRANT_LD);
        grant[1] = head_valid[1] && (!head_valid[0] || last_grant == GRANT_ALU);
        if (grant[0])
            last_grant_nxt = GRANT_ALU;
        else if (grant[1])
            last_grant_nxt = GRANT_LD;
    end

    assign gsel = grant[REQ_LD];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= GRANT_LD;
            for (int r = 0; r < 2; r++) begin
                rd_ptr[r] <= '0;
                wr_ptr[r] <= '0;
                count[r]  <= '0;
            end
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            conflict_q <= '0;
        end else begin
            last_grant <= last_grant_nxt;
            for (int r = 0; r < 2; r++) begin
                if (enq[r])
                    wr_ptr[r] <= wr_ptr[r] + 1'b1;
                if (grant[r])
                    rd_ptr[r] <= rd_ptr[r] + 1'b1;
                count[r] <= count[r] + (PTR_W+1)'(enq[r]) - (PTR_W+1)'(grant[r]);
            end
            rf_we_q <= |grant;
            if (|grant) begin
                rf_addr_q <= mem_addr[gsel][rd_ptr[gsel]];
                rf_data_q <= mem_data[gsel][rd_ptr[gsel]];
            end
            if ((&head_valid) && (conflict_q != '1))
                conflict_q <= conflict_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (enq[r]) begin
                mem_addr[r][wr_ptr[r]] <= in_addr[r];
                mem_data[r][wr_ptr[r]] <= in_data[r];
            end
        end
    end

    always_comb begin
        q_hit = 1'b0;
        if (bus.query_addr != '0) begin
            if (rf_we_q && rf_addr_q == bus.query_addr)
                q_hit = 1'b1;
            for (int r = 0; r < 2; r++)
                for (int s = 0; s < DEPTH; s++)
                    if (slot_valid[r][s] && mem_addr[r][s] == bus.query_addr)
                        q_hit = 1'b1;
        end
    end

`ifdef RF_WRITE_FORWARD_EN
    logic [0:DATA_W-1] fwd_data_c;
    logic              fwd_late;
    logic              fwd_req;
    logic [PTR_W-1:0]  fwd_slot;

    // Scan lowest priority first so later matches override: write stage, the requester
    // granted next, then the requester granted after it; oldest to newest within a FIFO.
    always_comb begin
        fwd_data_c = '0;
        fwd_late   = (last_grant == GRANT_LD);
        fwd_req    = 1'b0;
        fwd_slot   = '0;
        if (bus.query_addr != '0) begin
            if (rf_we_q && rf_addr_q == bus.query_addr)
                fwd_data_c = rf_data_q;
            for (int p = 0; p < 2; p++) begin
                fwd_req = (p == 1) ? fwd_late : !fwd_late;
                for (int k = 0; k < DEPTH; k++) begin
                    fwd_slot = rd_ptr[fwd_req] + PTR_W'(k);
                    if (((PTR_W+1)'(k) < count[fwd_req]) &&
                        (mem_addr[fwd_req][fwd_slot] == bus.query_addr))
                        fwd_data_c = mem_data[fwd_req][fwd_slot];
                end
            end
        end
    end

    assign bus.fwd_valid = q_hit;
    assign bus.fwd_data  = fwd_data_c;
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_data  = '0;
`endif

    assign bus.alu_ready     = ready[0];
    assign bus.ld_ready      = ready[1];
    assign bus.rf_we         = rf_we_q;
    assign bus.rf_addr       = rf_addr_q;
    assign bus.rf_data       = rf_data_q;
    assign bus.query_pending = q_hit;
    assign bus.conflict_cnt  = conflict_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: per-requester scoreboards of expected register-file writes.
module tb_rf_write_arbiter;
    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic clk;
    logic reset;

    rf_write_arbiter_if bus ();

    rf_write_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wr_t        alu_stim[$];
    wr_t        ld_stim[$];
    wr_t        alu_exp[$];
    wr_t        ld_exp[$];
    logic [4:0] addr_log[$];
    logic [4:0] tie_seq [6];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         ld_acc   = 0;
    int         ld_seen  = 0;
    bit         alu_fire;
    bit         ld_fire;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write();
        wr_t got;
        wr_t exp;
        got.addr = bus.rf_addr;
        got.data = bus.rf_data;
        addr_log.push_back(bus.rf_addr);
        if (alu_exp.size() != 0 && got == alu_exp[0]) begin
            exp = alu_exp.pop_front();
        end else if (ld_exp.size() != 0 && got == ld_exp[0]) begin
            exp = ld_exp.pop_front();
            ld_seen++;
        end else if (alu_exp.size() != 0) begin
            exp = alu_exp.pop_front();
        end else if (ld_exp.size() != 0) begin
            exp = ld_exp.pop_front();
        end else begin
            check("rf_we_unexpected", bus.rf_we, 0);
            return;
        end
        check("rf_write", got, exp);
    endtask

    // One clock: present queue heads, note handshakes, sample 1 time unit after the edge.
    task automatic cycle();
        wr_t w;
        bus.alu_valid = (alu_stim.size() != 0);
        bus.ld_valid  = (ld_stim.size() != 0);
        if (alu_stim.size() != 0) begin
            bus.alu_addr = alu_stim[0].addr;
            bus.alu_data = alu_stim[0].data;
        end
        if (ld_stim.size() != 0) begin
            bus.ld_addr = ld_stim[0].addr;
            bus.ld_data = ld_stim[0].data;
        end
        #1;
        alu_fire = bus.alu_valid && bus.alu_ready;
        ld_fire  = bus.ld_valid && bus.ld_ready;
        @(posedge clk);
        #1;
        if (alu_fire) begin
            w = alu_stim.pop_front();
            if (w.addr != 0) alu_exp.push_back(w);
        end
        if (ld_fire) begin
            w = ld_stim.pop_front();
            ld_acc++;
            if (w.addr != 0) ld_exp.push_back(w);
        end
        if (bus.rf_we) check_write();
    endtask

    task automatic clear_queues();
        alu_stim.delete();
        ld_stim.delete();
        alu_exp.delete();
        ld_exp.delete();
        addr_log.delete();
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
    endtask

    task automatic do_reset();
        clear_queues();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && (alu_stim.size() + ld_stim.size() + alu_exp.size() + ld_exp.size()) != 0; i++)
            cycle();
        check(tag, alu_stim.size() + ld_stim.size() + alu_exp.size() + ld_exp.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tie_seq = '{5'd3, 5'd4, 5'd3, 5'd4, 5'd3, 5'd4};
        reset          = 1'b0;
        bus.alu_valid  = 1'b0;
        bus.alu_addr   = '0;
        bus.alu_data   = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_data    = '0;
        bus.query_addr = '0;

        // Reset state
        #12;
        check("rst_rf_we", bus.rf_we, 0);
        check("rst_rf_addr", bus.rf_addr, 0);
        check("rst_rf_data", bus.rf_data, 0);
        check("rst_alu_ready", bus.alu_ready, 1);
        check("rst_ld_ready", bus.ld_ready, 1);
        check("rst_query", bus.query_pending, 0);
        check("rst_fwd_valid", bus.fwd_valid, 0);
        check("rst_fwd_data", bus.fwd_data, 0);
        check("rst_conflict", bus.conflict_cnt, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single write and its latency
        bus.query_addr = 5'd5;
        alu_stim.push_back('{5'd5, 64'h0123456789ABCDEF});
        cycle();
        check("single_accept", alu_fire, 1);
        check("single_pending_q", bus.query_pending, 1);
        check("single_we_early", bus.rf_we, 0);
        cycle();
        check("single_we", bus.rf_we, 1);
        check("single_addr", bus.rf_addr, 5);
        check("single_data", bus.rf_data, 64'h0123456789ABCDEF);
        check("single_pending_ws", bus.query_pending, 1);
        cycle();
        check("single_we_drop", bus.rf_we, 0);
        check("single_pending_off", bus.query_pending, 0);
        check("single_addr_hold", bus.rf_addr, 5);
        check("single_drained", alu_exp.size(), 0);

        // Register 0 is accepted but never written
        bus.query_addr = 5'd0;
        alu_stim.push_back('{5'd0, 64'hFFFFFFFFFFFFFFFF});
        cycle();
        check("r0_accept", alu_fire, 1);
        check("r0_pending", bus.query_pending, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("r0_no_we", bus.rf_we, 0);
            check("r0_pending_hold", bus.query_pending, 0);
        end

        // Tie round-robin from reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alu_stim.push_back('{5'd3, 64'hAAAAAAAAAAAAAAA0 + 64'(i)});
            ld_stim.push_back('{5'd4, 64'hBBBBBBBBBBBBBBB0 + 64'(i)});
        end
        drain("tie_drain");
        check("tie_count", addr_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < addr_log.size())
                check("tie_seq", addr_log[i], tie_seq[i]);
        check("tie_conflict", bus.conflict_cnt, 5);

        // Backpressure on LD while ALU competes
        ld_acc  = 0;
        ld_seen = 0;
        for (int i = 0; i < 4; i++) begin
            alu_stim.push_back('{5'(20 + i), 64'hA0A0000000000000 + 64'(i)});
            ld_stim.push_back('{5'(10 + i), 64'hB0B0000000000000 + 64'(i)});
        end
        cycle();
        cycle();
        check("bp_ld_acc", ld_acc, 2);
        check("bp_ld_ready", bus.ld_ready, 0);
        drain("bp_drain");
        check("bp_ld_seen", ld_seen, 4);
        check("bp_ld_acc_total", ld_acc, 4);

        // Reset mid-operation
        bus.query_addr = 5'd9;
        alu_stim.push_back('{5'd9, 64'h9999000000000001});
        alu_stim.push_back('{5'd9, 64'h9999000000000002});
        ld_stim.push_back('{5'd9, 64'h8888000000000001});
        ld_stim.push_back('{5'd9, 64'h8888000000000002});
        cycle();
        cycle();
        check("mid_pending_before", bus.query_pending, 1);
        reset = 1'b0;
        #1;
        check("mid_rf_we", bus.rf_we, 0);
        check("mid_alu_ready", bus.alu_ready, 1);
        check("mid_ld_ready", bus.ld_ready, 1);
        check("mid_pending", bus.query_pending, 0);
        check("mid_conflict", bus.conflict_cnt, 0);
        reset = 1'b1;
        clear_queues();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("mid_no_we", bus.rf_we, 0);
        end
        check("mid_conflict_after", bus.conflict_cnt, 0);

        // Forwarding of the youngest pending write
        bus.query_addr = 5'd7;
        alu_stim.push_back('{5'd7, 64'h1111111111111111});
        alu_stim.push_back('{5'd7, 64'h2222222222222222});
        cycle();
`ifdef RF_WRITE_FORWARD_EN
        check("fwd_valid_1", bus.fwd_valid, 1);
        check("fwd_data_1", bus.fwd_data, 64'h1111111111111111);
`else
        check("fwd_valid_1", bus.fwd_valid, 0);
        check("fwd_data_1", bus.fwd_data, 0);
`endif
        cycle();
        check("fwd_pending", bus.query_pending, 1);
`ifdef RF_WRITE_FORWARD_EN
        check("fwd_valid_2", bus.fwd_valid, 1);
        check("fwd_data_2", bus.fwd_data, 64'h2222222222222222);
`else
        check("fwd_valid_2", bus.fwd_valid, 0);
        check("fwd_data_2", bus.fwd_data, 0);
`endif
        drain("fwd_drain");
        cycle();
        check("fwd_valid_end", bus.fwd_valid, 0);
        check("fwd_pending_end", bus.query_pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
